rst_seq_ctrl: RTL
=================

Name: rst_seq_ctrl

Overview:
Parametrised reset sequencer that sits between the clock/reset generator and the SoC core. It turns one synchronous system reset, a raw reset push-button and a soft-reset request into NUM_RST staged, active-high domain resets. Power-on stretch, staged release order, button debounce and last-reset-cause reporting are all configurable.

Parameters:
NUM_RST, 4, number of reset domains; rst_out[0] releases first (range 1..16)
STRETCH_CYC, 16, cycles all resets are held after the sequence starts (>=1)
STAGE_GAP, 8, cycles between successive domain releases, and from the last release to ready (>=1)
DEB_CYC, 4, consecutive active synchronised samples needed to accept a button press (>=1)
SW_ACTIVE_LOW, 1, 1: reset_sw is pressed when 0; 0: pressed when 1
CNT_W, 8, width of stretch/gap counter; must hold max(STRETCH_CYC, STAGE_GAP)-1

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high system reset
reset_sw  input  1  raw asynchronous push-button, polarity per SW_ACTIVE_LOW
soft_req  input  1  level soft-reset request (watchdog/CSR), honoured only in RUN
soft_ack  output  1  one-cycle pulse: soft_req accepted
rst_out  output  NUM_RST  per-domain active-high resets
ready  output  1  high while all domains are released (state RUN)
rst_cause  output  2  cause of last sequence: 01 POR, 10 button, 11 soft

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset values while reset=1:
  - state ASSERT; rst_out all 1s; ready 0; soft_ack 0; rst_cause 01; counter 0.
  - Sync flops hold the inactive level; debounce count 0; press flag 0.
- FSM states: ASSERT, STRETCH, RELEASE, RUN.
  - ASSERT lasts one cycle, holds rst_out all 1s, loads cnt=STRETCH_CYC-1, then goes to STRETCH.
  - STRETCH: cnt decrements each cycle. On the edge where cnt==0: enter RELEASE, clear rst_out[0], set idx=0, load cnt=STAGE_GAP-1.
  - RELEASE: cnt decrements. On the edge where cnt==0:
    - if idx<NUM_RST-1: idx++, clear rst_out[idx+1], reload cnt.
    - else: enter RUN and set ready=1.
  - RUN: holds until a trigger arrives.
- Release timing. E0 is the first edge sampling reset=0.
  - rst_out[i] falls at edge E0+STRETCH_CYC+i*STAGE_GAP.
  - ready rises at edge E0+STRETCH_CYC+NUM_RST*STAGE_GAP.
  - Released bits never re-assert except through ASSERT.
- Button path:
  - 2-flop synchroniser.
  - Debounce counter increments on each cycle the synchronised level is active; it clears to 0 on any inactive sample; it saturates at DEB_CYC.
  - The press flag pulses for one cycle on the edge where the count reaches DEB_CYC.
  - A new press requires an inactive sample first; a held button yields one press.
  - Net latency: pressed level stable from before edge 1 gives rst_out all 1s after edge DEB_CYC+3.
  - Pulses shorter than DEB_CYC synchronised samples are ignored.
- Triggers, in priority order reset > press > soft:
  - press, in any state except ASSERT: next state ASSERT, rst_out all 1s, ready 0, rst_cause 10. The running sequence restarts from scratch.
  - soft_req=1 in RUN with no press: next state ASSERT, rst_out all 1s, ready 0, rst_cause 11, soft_ack=1 for exactly that one cycle.
  - soft_req outside RUN is ignored, with no ack. A soft_req still high when RUN is re-entered triggers again; the requester must drop it after soft_ack.
  - Press and soft_req in the same RUN cycle: press wins; rst_cause 10; no soft_ack.
- reset mid-sequence or in RUN: immediate return to reset values; rst_cause becomes 01.
- rst_cause updates only on entry to ASSERT and is stable otherwise.
- NUM_RST=1: a single release, then ready after STAGE_GAP cycles.

Test Plan:
1. Defaults, reset held 5 cycles then low at E0 -> rst_out=1111 until E0+16; rst_out[0]=0 at E0+16, [1] at E0+24, [2] at E0+32, [3] at E0+40; ready=1 at E0+48; rst_cause=01.
2. In RUN, drive reset_sw=0 (active-low) steady -> rst_out=1111 and ready=0 after 7 edges; rst_cause=10; full release sequence replays; holding the button produces no second restart.
3. In RUN, reset_sw glitch low for 3 cycles -> no change: rst_out=0000, ready stays 1.
4. In RUN, assert soft_req -> soft_ack high exactly one cycle, rst_out=1111 next edge, rst_cause=11; soft_req asserted during STRETCH -> no ack, no effect.
5. Press and soft_req in the same RUN cycle -> rst_cause=10, soft_ack stays 0. Press during RELEASE with idx=2 -> rst_out back to 1111 and sequence restarts from STRETCH.
6. Assert reset during RELEASE -> rst_out=1111, rst_cause=01 at the next edge. Separately, NUM_RST=1, STRETCH_CYC=1, STAGE_GAP=1 -> rst_out falls at E0+1 and ready rises at E0+2.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: turns the system reset, a debounced push-button and a
// soft-reset request into NUM_RST staged, active-high domain resets with a
// power-on stretch and a fixed gap between domain releases.
module rst_seq_ctrl #(
  parameter int unsigned NUM_RST       = 4,
  parameter int unsigned STRETCH_CYC   = 16,
  parameter int unsigned STAGE_GAP     = 8,
  parameter int unsigned DEB_CYC       = 4,
  parameter bit          SW_ACTIVE_LOW = 1'b1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               reset_sw,
  input  logic               soft_req,
  output logic               soft_ack,
  output logic [NUM_RST-1:0] rst_out,
  output logic               ready,
  output logic [1:0]         rst_cause
);

  localparam int unsigned IDX_W   = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
  localparam int unsigned DEB_W   = $clog2(DEB_CYC + 1);
  // Idle (released) level of the raw button.
  localparam logic        SW_IDLE = SW_ACTIVE_LOW;

  localparam logic [1:0] CAUSE_POR  = 2'b01;
  localparam logic [1:0] CAUSE_BTN  = 2'b10;
  localparam logic [1:0] CAUSE_SOFT = 2'b11;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  logic               sw_meta_q;
  logic               sw_sync_q;
  logic               sw_act;
  logic [DEB_W-1:0]   deb_cnt_q;
  logic [DEB_W-1:0]   deb_cnt_d;
  logic               press_q;
  logic               press_d;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_RST-1:0] rst_out_q;
  logic               ready_q;
  logic               soft_ack_q;
  logic [1:0]         cause_q;

  // Two-flop synchroniser for the asynchronous push-button.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_q <= SW_IDLE;
      sw_sync_q <= SW_IDLE;
    end else begin
      sw_meta_q <= reset_sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Debounce next-state: count active samples, saturate, flag the DEB_CYC-th.
  always_comb begin
    sw_act    = (sw_sync_q != SW_IDLE);
    deb_cnt_d = deb_cnt_q;
    press_d   = 1'b0;
    if (!sw_act) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DEB_W'(DEB_CYC)) begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
      press_d   = (deb_cnt_q == DEB_W'(DEB_CYC - 1));
    end
  end

  // Debounce counter and one-cycle press pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      press_q   <= press_d;
    end
  end

  // Sequencer FSM with registered outputs; triggers take priority press > soft.
  // Domains release by shifting zeros in from bit 0, so released bits stay
  // low until the next ASSERT reloads all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ASSERT;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_out_q  <= '1;
      ready_q    <= 1'b0;
      soft_ack_q <= 1'b0;
      cause_q    <= CAUSE_POR;
    end else begin
      soft_ack_q <= 1'b0;
      if (press_q && (state_q != ST_ASSERT)) begin
        state_q   <= ST_ASSERT;
        cnt_q     <= '0;
        rst_out_q <= '1;
        ready_q   <= 1'b0;
        cause_q   <= CAUSE_BTN;
      end else if (soft_req && (state_q == ST_RUN)) begin
        state_q    <= ST_ASSERT;
        cnt_q      <= '0;
        rst_out_q  <= '1;
        ready_q    <= 1'b0;
        soft_ack_q <= 1'b1;
        cause_q    <= CAUSE_SOFT;
      end else begin
        case (state_q)
          ST_ASSERT: begin
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            cnt_q     <= CNT_W'(STRETCH_CYC - 1);
            state_q   <= ST_STRETCH;
          end
          ST_STRETCH: begin
            if (cnt_q == '0) begin
              state_q   <= ST_RELEASE;
              rst_out_q <= rst_out_q << 1;
              idx_q     <= '0;
              cnt_q     <= CNT_W'(STAGE_GAP - 1);
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          ST_RELEASE: begin
            if (cnt_q == '0) begin
              if (idx_q != IDX_W'(NUM_RST - 1)) begin
                idx_q     <= idx_q + IDX_W'(1);
                rst_out_q <= rst_out_q << 1;
                cnt_q     <= CNT_W'(STAGE_GAP - 1);
              end else begin
                state_q <= ST_RUN;
                ready_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          default: begin
            state_q <= ST_RUN;
          end
        endcase
      end
    end
  end

  assign rst_out   = rst_out_q;
  assign ready     = ready_q;
  assign soft_ack  = soft_ack_q;
  assign rst_cause = cause_q;

endmodule
